// File: rtl/rf_multiport_if.sv
// Bus bundle for rf_multiport: decode/writeback side drives the master modport,
// the register file sits on the slave modport.
interface rf_multiport_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] rw;
  logic [DATA_W-1:0] rd;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [DATA_W-1:0] qa;
  logic [DATA_W-1:0] qb;
  logic              clr_req;
  logic              busy;
  logic              clr_done;
  logic              wr_drop;
  logic [DATA_W-1:0] tap0;
  logic [DATA_W-1:0] tap1;
  logic [DATA_W-1:0] tap2;
  logic [DATA_W-1:0] tap3;

  modport master (
    output we, rw, rd, ra, rb, clr_req,
    input  qa, qb, busy, clr_done, wr_drop, tap0, tap1, tap2, tap3
  );

  modport slave (
    input  we, rw, rd, ra, rb, clr_req,
    output qa, qb, busy, clr_done, wr_drop, tap0, tap1, tap2, tap3
  );
endinterface

// File: rtl/rf_multiport.sv
// Register file: 2 combinational reads, 1 write, r0 = 0, clear sequencer, debug taps.
// Optional write-to-read forwarding when RF_MULTIPORT_BYPASS_EN is defined.
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int TAP0_IDX = 8,
  parameter int TAP1_IDX = 16,
  parameter int TAP2_IDX = 17,
  parameter int TAP3_IDX = 18
) (
  input logic          clk,
  input logic          clr_n,
  rf_multiport_if.slave bus
);
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] T0       = ADDR_W'(TAP0_IDX);
  localparam logic [ADDR_W-1:0] T1       = ADDR_W'(TAP1_IDX);
  localparam logic [ADDR_W-1:0] T2       = ADDR_W'(TAP2_IDX);
  localparam logic [ADDR_W-1:0] T3       = ADDR_W'(TAP3_IDX);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_en;
  logic              clr_en;
  logic              clr_last;
  logic              drop_c;
  logic              fwd_a;
  logic              fwd_b;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_next;
  end

  // Requests arriving while already clearing are ignored; no restart.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.clr_req) state_next = CLEAR;
      CLEAR:   if (clr_idx == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clr_en   = (state == CLEAR);
    clr_last = clr_en && (clr_idx == LAST_IDX);
    wr_en    = (state == IDLE) && bus.we && (bus.rw != '0);
    drop_c   = clr_en && bus.we && (bus.rw != '0);
    bus.busy = clr_en;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      clr_idx <= ADDR_W'(1);
    end else if (clr_en) begin
      clr_idx <= clr_last ? ADDR_W'(1) : clr_idx + ADDR_W'(1);
    end
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      mem[bus.rw] <= bus.rd;
    end
  end

  // Taps sample pre-edge contents, so they trail the array by one cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus.clr_done <= 1'b0;
      bus.wr_drop  <= 1'b0;
      bus.tap0     <= '0;
      bus.tap1     <= '0;
      bus.tap2     <= '0;
      bus.tap3     <= '0;
    end else begin
      bus.clr_done <= clr_last;
      bus.wr_drop  <= drop_c;
      bus.tap0     <= (TAP0_IDX == 0) ? '0 : mem[T0];
      bus.tap1     <= (TAP1_IDX == 0) ? '0 : mem[T1];
      bus.tap2     <= (TAP2_IDX == 0) ? '0 : mem[T2];
      bus.tap3     <= (TAP3_IDX == 0) ? '0 : mem[T3];
    end
  end

`ifdef RF_MULTIPORT_BYPASS_EN
  always_comb begin
    fwd_a = wr_en && (bus.ra == bus.rw);
    fwd_b = wr_en && (bus.rb == bus.rw);
  end
`else
  always_comb begin
    fwd_a = 1'b0;
    fwd_b = 1'b0;
  end
`endif

  always_comb begin
    if (bus.ra == '0)  bus.qa = '0;
    else if (fwd_a)    bus.qa = bus.rd;
    else               bus.qa = mem[bus.ra];
    if (bus.rb == '0)  bus.qb = '0;
    else if (fwd_b)    bus.qb = bus.rd;
    else               bus.qb = mem[bus.rb];
  end
endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
Parametrised general-purpose register file for the CPU datapath: DEPTH x DATA_W storage, two combinational read ports, one write port, register 0 hardwired to zero. Adds a multi-cycle clear sequencer and four registered debug taps with parameter-selected indices, which feed the board display and the bench. Sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W
TAP0_IDX, 8, register index mirrored on tap0
TAP1_IDX, 16, register index mirrored on tap1
TAP2_IDX, 17, register index mirrored on tap2
TAP3_IDX, 18, register index mirrored on tap3

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
we  in  1  write enable
rw  in  ADDR_W  write address
rd  in  DATA_W  write data
ra  in  ADDR_W  read address A
rb  in  ADDR_W  read address B
qa  out  DATA_W  read data A, combinational
qb  out  DATA_W  read data B, combinational
clr_req  in  1  synchronous request to zero the whole file via the sequencer
busy  out  1  high while the clear sequencer runs
clr_done  out  1  one-cycle pulse when the clear completes
wr_drop  out  1  one-cycle pulse: write attempted while busy and discarded
tap0..tap3  out  DATA_W each  registered copies of the TAPn_IDX registers

Behaviour:
- Reset (clr_n=0, asynchronous): all storage=0; tap0..3=0; busy=0; clr_done=0; wr_drop=0; FSM=IDLE; clear index=1. Outputs hold these values until the first clk edge after release.
- Read: qa = (ra==0) ? 0 : mem[ra]; qb likewise. Zero latency. Register 0 always reads 0, including during clear and bypass.
- Write: at a rising edge with we=1, rw!=0 and FSM=IDLE, mem[rw] <= rd. Writes to rw=0 are silently ignored and do not raise wr_drop.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR, busy=1 next cycle, index=1. A write in the same cycle as clr_req is performed, because the FSM is still IDLE.
  - CLEAR: each edge writes mem[index] <= 0 and increments index. After index DEPTH-1 is written -> IDLE, busy=0, clr_done=1 for one cycle, index reset to 1. A clear takes DEPTH-1 cycles.
  - clr_req while in CLEAR is ignored and does not restart the sequence.
  - we=1 with rw!=0 while in CLEAR: the write is discarded and wr_drop pulses on the next cycle.
- Reads during CLEAR return current contents: already-cleared entries read 0, the rest read old values.
- Taps: each edge, tapN <= mem[TAPN_IDX] as it was before that edge's write, giving a 1-cycle-delayed mirror, so a write becomes visible on a tap 2 edges later. A TAPn_IDX of 0 gives a constant 0.
- clr_n asserted mid-CLEAR aborts the sequence immediately; the file is zero and the FSM is IDLE.
- No arithmetic; index counter is ADDR_W bits and never wraps because the terminal value is DEPTH-1.

Optional Feature:
Macro RF_MULTIPORT_BYPASS_EN.
- Defined: write-to-read forwarding. If we=1, rw!=0, FSM=IDLE and ra==rw, then qa=rd in the same cycle; likewise qb when rb==rw. Register 0 is never forwarded.
- Undefined: qa/qb return the stored value; new data is readable the cycle after the write edge.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 and 0x12345678 to r0; read ra=5, rb=0 -> qa=0xDEADBEEF, qb=0.
- Write 0xA5A5A5A5 to r8 at edge N -> tap0=0xA5A5A5A5 after edge N+1 and not before; tap1..3 stay 0.
- Fill r1..r31 with the value index*0x11, pulse clr_req -> busy=1 for 31 cycles, clr_done pulses once, all reads return 0; sample ra=20 mid-clear at index 10 -> still reads 0x154.
- During CLEAR drive we=1, rw=3, rd=0x77 -> wr_drop pulses and r3 reads 0 after done; a second clr_req mid-clear -> total busy stays 31 cycles.
- Assert clr_n at clear index 12 -> busy=0 and all registers 0 immediately; release, write r7=0x5 -> reads 0x5.
- With RF_MULTIPORT_BYPASS_EN: we=1, rw=9, rd=0xCAFE, ra=9 -> qa=0xCAFE in the same cycle. Without the macro: qa shows the old value until after the edge.
